// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I memory stage: aligns stores, extends loads, flags misaligned ops
//
// Purpose: takes the ALU effective address and drives a word-wide data
// memory port through a req/ack handshake. A transaction is accepted only in
// IDLE; the stage stalls (req_ready low) while it waits for mem_ack.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   req_valid/req_ready      execute-stage handshake
//   req_addr/req_wdata       effective address and store data (rs2)
//   req_we/req_funct3/req_rd store flag, access size/sign, load destination
//   flush                    squash acceptance (IDLE) or completion (WAIT)
//   mem_req/mem_we/mem_addr/mem_wdata/mem_be   bus request, held until ack
//   mem_ack/mem_rdata        bus completion and read word (same cycle)
//   done/wb_en/wb_rd/wb_data one-cycle completion pulse and writeback
//   exc_misalign/exc_store/exc_addr            one-cycle exception pulse
module load_store_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    input  logic            req_we,
    input  logic [2:0]      req_funct3,
    input  logic [4:0]      req_rd,
    input  logic            flush,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            done,
    output logic            wb_en,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_data,
    output logic            exc_misalign,
    output logic            exc_store,
    output logic [XLEN-1:0] exc_addr
);

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t      r_state;
    logic        r_flushed;   // a flush was seen while waiting for ack
    logic [2:0]  r_funct3;
    logic [4:0]  r_rd;
    logic [1:0]  r_addr_lo;

    logic            w_accept;
    logic            w_legal;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [XLEN-1:0] w_load_data;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready && !flush;

    // Unsigned sizes exist only for loads; stores accept B/H/W only.
    always_comb begin
        w_legal = 1'b0;
        case (req_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = !req_addr[0];
            3'b010:  w_legal = (req_addr[1:0] == 2'b00);
            3'b100:  w_legal = !req_we;
            3'b101:  w_legal = !req_we && !req_addr[0];
            default: w_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the size for both signed and unsigned variants.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = req_wdata;
        case (req_funct3[1:0])
            2'b00: begin
                w_be    = 4'b0001 << req_addr[1:0];
                w_wdata = {4{req_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = 4'b0011 << {req_addr[1], 1'b0};
                w_wdata = {2{req_wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wdata = req_wdata;
            end
        endcase
    end

    always_comb begin
        w_byte = mem_rdata[7:0];
        case (r_addr_lo)
            2'b00:   w_byte = mem_rdata[7:0];
            2'b01:   w_byte = mem_rdata[15:8];
            2'b10:   w_byte = mem_rdata[23:16];
            default: w_byte = mem_rdata[31:24];
        endcase
        w_half = r_addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (r_funct3)
            3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
            3'b100:  w_load_data = {24'd0, w_byte};
            3'b101:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_flushed    <= 1'b0;
            r_funct3     <= 3'd0;
            r_rd         <= 5'd0;
            r_addr_lo    <= 2'd0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= 4'd0;
            done         <= 1'b0;
            wb_en        <= 1'b0;
            wb_rd        <= 5'd0;
            wb_data      <= '0;
            exc_misalign <= 1'b0;
            exc_store    <= 1'b0;
            exc_addr     <= '0;
        end else begin
            done         <= 1'b0;
            wb_en        <= 1'b0;
            exc_misalign <= 1'b0;
            exc_store    <= 1'b0;
            exc_addr     <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_legal) begin
                            r_state   <= S_WAIT;
                            r_flushed <= 1'b0;
                            r_funct3  <= req_funct3;
                            r_rd      <= req_rd;
                            r_addr_lo <= req_addr[1:0];
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                            mem_wdata <= w_wdata;
                            mem_be    <= w_be;
                        end else begin
                            exc_misalign <= 1'b1;
                            exc_store    <= req_we;
                            exc_addr     <= req_addr;
                        end
                    end
                end
                S_WAIT: begin
                    if (flush) begin
                        r_flushed <= 1'b1;
                    end
                    // The bus transaction always completes; flush only hides it.
                    if (mem_ack) begin
                        r_state <= S_IDLE;
                        mem_req <= 1'b0;
                        if (!r_flushed && !flush) begin
                            done <= 1'b1;
                            if (!mem_we) begin
                                wb_en   <= (r_rd != 5'd0);
                                wb_rd   <= r_rd;
                                wb_data <= w_load_data;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Memory stage of the core, directly downstream of the ALU. It takes the ALU result as the effective address for RV32I loads and stores and drives a word-wide data-memory port through a req/ack handshake. It aligns store data and byte enables, extracts and extends load data, and reports misaligned accesses. The pipeline stalls on `req_ready` while a transaction is outstanding.

## Interface
- `XLEN`, 32, data/address width; 32 is the only legal value.

- `clk` in 1 — clock, rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — execute stage presents a memory op.
- `req_ready` out 1 — `(state==IDLE) && !rst`.
- `req_addr` in 32 — effective address (ALU `op`).
- `req_wdata` in 32 — store data (rs2).
- `req_we` in 1 — 1 = store, 0 = load.
- `req_funct3` in 3 — 000 B, 001 H, 010 W, 100 BU, 101 HU.
- `req_rd` in 5 — load destination register.
- `flush` in 1 — squash the current or pending op's completion.
- `mem_req` out 1 — bus request.
- `mem_we` out 1 — bus write.
- `mem_addr` out 32 — `{addr[31:2],2'b00}`.
- `mem_wdata` out 32 — lane-replicated store data.
- `mem_be` out 4 — byte enables.
- `mem_ack` in 1 — bus completion; `mem_rdata` is valid in the same cycle.
- `mem_rdata` in 32 — read word.
- `done` out 1 — one-cycle completion pulse, loads and stores.
- `wb_en` out 1 — pulse with `done` for loads with rd≠0.
- `wb_rd` out 5 — destination register.
- `wb_data` out 32 — extended load data.
- `exc_misalign` out 1 — one-cycle exception pulse.
- `exc_store` out 1 — exception came from a store.
- `exc_addr` out 32 — faulting address.

## Operation
- States: IDLE, WAIT.
  - IDLE→WAIT on accept with a legal op.
  - IDLE→IDLE on accept with an illegal op (exception pulse).
  - WAIT→IDLE on `mem_ack`.
- Accept means `req_valid && req_ready && !flush`. On accept, capture addr, wdata, we, funct3 and rd.
- Legality:
  - H/HU requires `addr[0]==0`; W requires `addr[1:0]==0`.
  - funct3 011, 110, 111 are illegal for loads. Stores allow only 000, 001, 010.
  - Illegal ops raise `exc_misalign`, never assert `mem_req`, and give no `done`.
- Byte enables: B = `4'b0001<<addr[1:0]`; H = `4'b0011<<{addr[1],1'b0}`; W = `4'b1111`. The same rule applies to loads.
- Store data: B = `{4{wdata[7:0]}}`; H = `{2{wdata[15:0]}}`; W = wdata.
- Load extraction:
  - Select the byte at `addr[1:0]` or the half at `addr[1]`.
  - B/H sign-extend from bit 7/15; BU/HU zero-extend; W passes through.
- In WAIT, `mem_req` stays 1. `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` stay stable until ack.
- Flush:
  - `flush` in IDLE blocks acceptance that cycle.
  - `flush` during WAIT, or in the ack cycle, lets the bus transaction finish but suppresses `done` and `wb_en`.
- Reset:
  - All registered outputs go to 0 and state goes to IDLE.
  - Reset during WAIT drops `mem_req` the next cycle; the bus must discard the transaction.

## Timing
- Accept at cycle t0. `mem_req` is high from t0+1; the earliest ack is at t0+1.
- Ack at cycle ta gives `done`, `wb_en`, `wb_rd` and `wb_data` registered at ta+1 for exactly one cycle.
- `req_ready` is high at ta+1, so back-to-back accept at ta+1 is allowed. Minimum period is 2 cycles per op.
- Exception path: accept at t0 gives `exc_misalign`, `exc_store` and `exc_addr` at t0+1 for one cycle. `req_ready` stays high throughout.
- `wb_data` and `wb_rd` hold their last value when `done`=0; `wb_en` is 0 outside the pulse.
- After reset, all outputs are 0 and `req_ready` goes to 1 the first cycle `rst` is low.

## Test plan
- LB, addr 0x1003, rdata 0x80FF_1234, ack at t0+1: `mem_addr`=0x1000, `mem_be`=1000, `done`/`wb_en` at t0+2, `wb_data`=0xFFFF_FF80. LBU of the same gives 0x0000_0080.
- SH, addr 0x2002, wdata 0xDEAD_BEEF, ack delayed 3 cycles: `mem_we`=1, `mem_be`=1100, `mem_wdata`=0xBEEF_BEEF, all held stable until ack. `done`=1, `wb_en`=0.
- LW addr 0x3001 and SH addr 0x3003: no `mem_req`; `exc_misalign` at t0+1 with `exc_addr`=0x3001 then 0x3003; `exc_store`=0 then 1.
- Back-to-back: LW rd=5, then LH rd=0 accepted at ta+1. Two `done` pulses; `wb_en` only for rd=5; `mem_req` low for exactly one cycle between the ops.
- `flush` during WAIT of LW rd=7: ack completes, `done`=`wb_en`=0, `req_ready` returns to 1.
- `rst` asserted in WAIT: `mem_req`=0 and all outputs 0 next cycle. A late ack is ignored, and a new LW proceeds normally.
